gray_bcd_display_scan: RTL and testbench
========================================

Name: gray_bcd_display_scan

Overview:
- Parametrised Gray-code-to-decimal display driver.
- Synchronises a WIDTH-bit Gray input and converts it to binary.
- Converts the binary value to BCD with a sequential double-dabble FSM.
- Time-multiplexes DIGITS seven-segment digits. Replaces the fixed 4-bit, two-digit combinational decode path.

Parameters:
- WIDTH, 4, Gray/binary input width in bits (>=2).
- DIGITS, 2, number of display digits; must satisfy 10^DIGITS > 2^WIDTH-1.
- REFRESH_DIV, 27000, clk cycles each digit stays active (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- gray_code  input  WIDTH  Gray-coded value from switches (asynchronous to clk).
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- anode  output  DIGITS  digit enables, active-low one-hot; bit 0 = units.
- bin_value  output  WIDTH  last fully converted binary value, registered.
- busy  output  1  high while a conversion is in flight.

Behaviour:
- Reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, all flops clear immediately.
- Reset values:
  - sync stages = 0, last_gray = 0, bcd register = 0, bin_value = 0, busy = 0.
  - digit index = 0, prescaler = 0.
  - Outputs: anode = all ones except bit0 = 0; seg = 7'b1000000 ("0").
- Input sync: 2-flop synchroniser on gray_code. All logic uses the synchronised value gs.
- Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE: if gs != last_gray, then last_gray <= gs, load shift register with the binary of gs, clear BCD scratch, cycle count <= 0, go to CONVERT. Otherwise stay in IDLE.
  - CONVERT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left 1. After exactly WIDTH cycles, go to LOAD.
  - LOAD: bcd register <= scratch; bin_value <= latched binary; go to IDLE.
- busy = 1 in CONVERT and LOAD.
- Latency: WIDTH+2 clk from gs changing to bcd/bin_value updating, plus 2 synchroniser cycles.
- Input change during CONVERT/LOAD: ignored until the FSM returns to IDLE. It is then detected against last_gray and converted. No conversion is ever aborted except by reset.
- Scanning:
  - Prescaler counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the digit index increments, wrapping DIGITS-1 → 0.
  - anode = ~(1 << index).
  - seg = 7-segment pattern of BCD nibble[index]. Nibble values 10..15 produce blank (7'b1111111).
  - Scanning runs independently of the FSM. The display updates atomically at LOAD.
- Reset mid-conversion: the conversion is lost, with no partial value displayed. After release, last_gray = 0, so a non-zero input triggers a fresh conversion.
- Digit patterns (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit whose nibble and all higher nibbles are zero shows blank (seg = 7'b1111111). Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all DIGITS digits always display, leading zeros included.

Test Plan:
- Reset: assert rst mid-cycle → outputs change without a clk edge: anode=2'b10, seg=7'b1000000, busy=0, bin_value=0.
- Full scale (WIDTH=4): gray_code=4'b1000 → busy high exactly 5 cycles, bin_value=15. Digit0 seg=7'b0010010 ("5"), digit1 seg=7'b1111001 ("1").
- Leading zero (gray_code=4'b0110 → 4): with LEADING_ZERO_BLANK_EN, digit1 seg=7'b1111111. Without it, digit1 seg=7'b1000000. Digit0 seg=7'b0011001 in both cases.
- Change mid-conversion: apply 4'b1000, then 4'b0001 two cycles after busy rises → bin_value reaches 15, then 1. busy drops to 0 between the two conversions.
- Scan wrap: REFRESH_DIV=4, DIGITS=2 → anode sequence 10, 01, 10, each held exactly 4 cycles.
- Wide config (WIDTH=8, DIGITS=3): gray_code=8'b10000000 → bin_value=255, digits "2","5","5". Assert rst during CONVERT → display stays "0", then 255 appears after release and reconversion.

Source files
------------

// File: rtl/gray_bcd_display_scan.sv
// gray_bcd_display_scan
//   Gray-coded switch input -> synchronised -> binary -> BCD through a sequential
//   double-dabble engine -> time-multiplexed, active-low seven-segment display.
//   Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits; digit 0 always shows.
module gray_bcd_display_scan #(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 27000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  gray_code,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] anode,
  output logic [WIDTH-1:0]  bin_value,
  output logic              busy
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PREW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_gs;
  logic [WIDTH-1:0]  r_lastGray;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  r_binLatch;
  logic [WIDTH-1:0]  r_binValue;
  logic [WIDTH-1:0]  w_gsBin;
  logic [BCDW-1:0]   r_scratch;
  logic [BCDW-1:0]   r_bcd;
  logic [BCDW-1:0]   w_adjusted;
  logic [CNTW-1:0]   r_cycleCnt;
  logic [PREW-1:0]   r_prescale;
  logic [IDXW-1:0]   r_digitIdx;
  logic [3:0]        w_nibble;
  logic              w_blank;

  // Two-flop synchroniser: the switches are asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_gs    <= '0;
    end else begin
      r_sync1 <= gray_code;
      r_gs    <= r_sync1;
    end
  end

  // Gray to binary: bit i is the XOR of all Gray bits at or above i
  always_comb begin
    w_gsBin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_gsBin[i] = ^(r_gs >> i);
    end
  end

  // Double-dabble correction: every BCD nibble of 5 or more gets 3 added before the shift
  always_comb begin
    w_adjusted = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adjusted[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: start on a new input, shift WIDTH times, then publish
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_gs != r_lastGray) w_nextState = CONVERT;
      CONVERT: if (r_cycleCnt == CNTW'(WIDTH - 1)) w_nextState = LOAD;
      LOAD:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Conversion datapath; the displayed BCD and bin_value only change together in LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGray <= '0;
      r_shift    <= '0;
      r_binLatch <= '0;
      r_scratch  <= '0;
      r_cycleCnt <= '0;
      r_bcd      <= '0;
      r_binValue <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_gs != r_lastGray) begin
            r_lastGray <= r_gs;
            r_shift    <= w_gsBin;
            r_binLatch <= w_gsBin;
            r_scratch  <= '0;
            r_cycleCnt <= '0;
          end
        end
        CONVERT: begin
          r_scratch  <= {w_adjusted[BCDW-2:0], r_shift[WIDTH-1]};
          r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
          r_cycleCnt <= r_cycleCnt + 1'b1;
        end
        LOAD: begin
          r_bcd      <= r_scratch;
          r_binValue <= r_binLatch;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign bin_value = r_binValue;

  // Refresh prescaler and digit index; free-running, independent of conversions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
      r_digitIdx <= '0;
    end else if (r_prescale == PREW'(REFRESH_DIV - 1)) begin
      r_prescale <= '0;
      r_digitIdx <= (r_digitIdx == IDXW'(DIGITS - 1)) ? '0 : r_digitIdx + 1'b1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // Select the active digit's nibble and drive its active-low anode
  always_comb begin
    w_nibble = 4'd0;
    anode    = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_digitIdx == IDXW'(d)) begin
        w_nibble = r_bcd[4*d +: 4];
        anode[d] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank the active digit when it and every higher digit are zero, except digit 0
  always_comb begin
    w_blank = (r_digitIdx != '0);
    for (int d = 0; d < DIGITS; d++) begin
      if ((IDXW'(d) >= r_digitIdx) && (r_bcd[4*d +: 4] != 4'd0)) begin
        w_blank = 1'b0;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Seven-segment decode, active-low gfedcba; 10..15 and blanked digits go dark
  always_comb begin
    seg = 7'b1111111;
    if (!w_blank) begin
      case (w_nibble)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_bcd_display_scan.sv
// tb_gray_bcd_display_scan
//   Scoreboard bench: applyStimulus pushes the expected binary value of every new
//   Gray input; a monitor pops on each busy falling edge and compares bin_value,
//   busy length and the visible digit. A second, wider instance covers 8-bit/3-digit.
//   Expected values follow LEADING_ZERO_BLANK_EN the same way the design does.
module tb_gray_bcd_display_scan;

  localparam int WIDTH   = 4;
  localparam int DIGITS  = 2;
  localparam int RDIV    = 4;
  localparam int WIDTHW  = 8;
  localparam int DIGITSW = 3;
  localparam int RDIVW   = 3;

  logic                clk;
  logic                rst;
  logic [WIDTH-1:0]    grayCode;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   anode;
  logic [WIDTH-1:0]    binValue;
  logic                busy;

  logic                rstW;
  logic [WIDTHW-1:0]   grayCodeW;
  logic [6:0]          segW;
  logic [DIGITSW-1:0]  anodeW;
  logic [WIDTHW-1:0]   binValueW;
  logic                busyW;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int expQ[$];
  int modelLastGray  = 0;
  bit wideDone       = 0;

  gray_bcd_display_scan #(.WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .gray_code(grayCode), .seg(seg),
    .anode(anode), .bin_value(binValue), .busy(busy)
  );

  gray_bcd_display_scan #(.WIDTH(WIDTHW), .DIGITS(DIGITSW), .REFRESH_DIV(RDIVW)) dutWide (
    .clk(clk), .rst(rstW), .gray_code(grayCodeW), .seg(segW),
    .anode(anodeW), .bin_value(binValueW), .busy(busyW)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: binary value is the XOR of the Gray word with all its right shifts
  function automatic int grayToBinary(input int g);
    int b = g;
    for (int s = 1; s < 32; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int digitPattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments of decimal digit 'digit' of 'value'; -1 digit gives an impossible code
  function automatic int expectedSeg(input int value, input int digit);
    int v = value;
    int pow = 1;
    if (digit < 0) return 'h1FF;
    for (int k = 0; k < digit; k++) begin
      v = v / 10;
      pow = pow * 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (digit > 0 && value < pow) return 7'b1111111;
`endif
    return digitPattern(v % 10);
  endfunction

  // Index of the single low anode bit, or -1 if the anode word is not one-cold
  function automatic int anodeIndex(input int a, input int n);
    int idx = -1;
    int zeros = 0;
    for (int k = 0; k < n; k++) begin
      if (((a >> k) & 1) == 0) begin
        idx = k;
        zeros++;
      end
    end
    return (zeros == 1) ? idx : -1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectorsApplied++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a Gray value; a conversion is expected only when it differs from the last one seen
  task automatic applyStimulus(input logic [WIDTH-1:0] g);
    grayCode = g;
    if (int'(g) != modelLastGray) begin
      expQ.push_back(grayToBinary(int'(g)));
      modelLastGray = int'(g);
    end
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 100; c++) begin
      if (expQ.size() == 0 && !busy) break;
      @(negedge clk);
    end
    checkOutput("drain pending", expQ.size(), 0);
  endtask

  task automatic checkDisplay(input int value);
    for (int c = 0; c < DIGITS * RDIV; c++) begin
      @(negedge clk);
      checkOutput("digit seg", int'(seg), expectedSeg(value, anodeIndex(int'(anode), DIGITS)));
    end
  endtask

  // Monitor: every busy fall is one finished conversion; compare against the scoreboard head
  initial begin
    int busyCycles;
    logic prevBusy;
    int expBin;
    busyCycles = 0;
    prevBusy   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busyCycles = 0;
        prevBusy   = 1'b0;
      end else begin
        if (busy) begin
          busyCycles++;
        end else if (prevBusy) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected conversion", 1, 0);
          end else begin
            expBin = expQ.pop_front();
            checkOutput("bin_value", int'(binValue), expBin);
            checkOutput("busy length", busyCycles, WIDTH + 1);
            checkOutput("seg at load", int'(seg),
                        expectedSeg(expBin, anodeIndex(int'(anode), DIGITS)));
          end
          busyCycles = 0;
        end
        prevBusy = busy;
      end
    end
  end

  // Wide instance: full-scale 255, reset during CONVERT, reconversion after release
  initial begin
    rstW = 1'b1;
    grayCodeW = 8'b10000000;
    repeat (2) @(negedge clk);
    rstW = 1'b0;
    for (int c = 0; c < 20 && !busyW; c++) @(negedge clk);
    checkOutput("wide busy rise", int'(busyW), 1);
    checkOutput("wide bin before load", int'(binValueW), 0);
    repeat (2) @(negedge clk);
    #2 rstW = 1'b1;
    #1;
    checkOutput("wide reset bin", int'(binValueW), 0);
    checkOutput("wide reset busy", int'(busyW), 0);
    checkOutput("wide reset anode", int'(anodeW), 3'b110);
    checkOutput("wide reset seg", int'(segW), 7'b1000000);
    repeat (2) @(negedge clk);
    rstW = 1'b0;
    for (int c = 0; c < 20 && !busyW; c++) @(negedge clk);
    checkOutput("wide reconvert rise", int'(busyW), 1);
    for (int c = 0; c < 30 && busyW; c++) @(negedge clk);
    checkOutput("wide reconvert fall", int'(busyW), 0);
    checkOutput("wide bin", int'(binValueW), 255);
    for (int c = 0; c < DIGITSW * RDIVW; c++) begin
      @(negedge clk);
      checkOutput("wide digit seg", int'(segW),
                  expectedSeg(255, anodeIndex(int'(anodeW), DIGITSW)));
    end
    wideDone = 1'b1;
  end

  // Main sequence for the 4-bit, 2-digit instance
  initial begin
    logic [DIGITS-1:0] prevAnode;
    logic [DIGITS-1:0] expAnode;
    int startIdx;
    int binRand;

    rst = 1'b1;
    grayCode = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset anode", int'(anode), 2'b10);
    checkOutput("reset seg", int'(seg), 7'b1000000);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset bin", int'(binValue), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full scale: 1000 -> 15
    applyStimulus(4'b1000);
    waitDrain();
    checkDisplay(15);

    // Leading zero: 0110 -> 4
    applyStimulus(4'b0110);
    waitDrain();
    checkDisplay(4);

    // Change two cycles into a conversion: 15 completes, then 1
    applyStimulus(4'b1000);
    for (int c = 0; c < 20 && !busy; c++) @(negedge clk);
    checkOutput("mid busy rise", int'(busy), 1);
    repeat (2) @(negedge clk);
    applyStimulus(4'b0001);
    waitDrain();
    checkDisplay(1);

    // Scan wrap: each digit held RDIV cycles, alternating
    prevAnode = anode;
    for (int c = 0; c < 2 * RDIV + 2 && anode == prevAnode; c++) @(negedge clk);
    checkOutput("scan change seen", int'(anode != prevAnode), 1);
    startIdx = anodeIndex(int'(anode), DIGITS);
    if (startIdx < 0) startIdx = 0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < RDIV; c++) begin
        expAnode = '1;
        expAnode[(startIdx + k) % DIGITS] = 1'b0;
        checkOutput("scan anode", int'(anode), int'(expAnode));
        @(negedge clk);
      end
    end

    // Randomised values, each allowed to finish
    for (int n = 0; n < 25; n++) begin
      binRand = int'($urandom_range(0, 15));
      applyStimulus(4'((binRand ^ (binRand >> 1)) & 15));
      waitDrain();
    end

    // Asynchronous reset mid-cycle with a non-zero value displayed
    applyStimulus(4'b0111);
    waitDrain();
    @(posedge clk);
    #3 rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("async reset anode", int'(anode), 2'b10);
    checkOutput("async reset seg", int'(seg), 7'b1000000);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset bin", int'(binValue), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelLastGray = 0;
    applyStimulus(grayCode);
    waitDrain();
    checkDisplay(5);

    for (int c = 0; c < 200 && !wideDone; c++) @(negedge clk);
    checkOutput("wide sequence done", int'(wideDone), 1);
    checkOutput("scoreboard empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
